// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined fp_mul
// between NUM_REQ requesters, with a latency-matched id tag pipe.
module fp_mul_arbiter #(
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [DATA_W-1:0]         mul_res,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ-1);

  logic [ID_W-1:0]            rr_ptr;
  logic [ID_W-1:0]            win;
  logic                       hit;
  logic [NUM_REQ-1:0]         gnt;
  logic [MUL_LAT:0]           tag_v;
  logic [MUL_LAT:0][ID_W-1:0] tag_id;
  logic [DATA_W-1:0]          sel_a;
  logic [DATA_W-1:0]          sel_b;

  // search starts one past the last winner and wraps
  always_comb begin
    int              idx;
    logic [ID_W-1:0] iw;
    gnt = '0;
    win = '0;
    hit = 1'b0;
    idx = 0;
    iw  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      iw = ID_W'(idx);
      if (!hit && en && rst && req_valid[iw]) begin
        hit     = 1'b1;
        win     = iw;
        gnt[iw] = 1'b1;
      end
    end
  end

  assign req_ready = gnt;
  assign sel_a     = req_a[win*DATA_W +: DATA_W];
  assign sel_b     = req_b[win*DATA_W +: DATA_W];
  assign busy      = (|tag_v) | (|rsp_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= LAST;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (hit) rr_ptr <= win;
      mul_a  <= hit ? sel_a : '0;
      mul_b  <= hit ? sel_b : '0;
      tag_v  <= {tag_v[MUL_LAT-1:0], hit};
      tag_id <= {tag_id[MUL_LAT-1:0], win};
      // last tag stage is aligned with mul_res
      if (tag_v[MUL_LAT]) begin
        rsp_valid <= NUM_REQ'(1) << tag_id[MUL_LAT];
        rsp_data  <= mul_res;
        rsp_id    <= tag_id[MUL_LAT];
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: scoreboard bench for fp_mul_arbiter
// with a behavioural 4-cycle fp_mul model.
module tb_fp_mul_arbiter;

  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 4;
  localparam int LAT     = MUL_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [DATA_W-1:0]         mul_a, mul_b, mul_res, rsp_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // requester i multiplies 2.0 by (i+1).0
  logic [31:0] opb  [4] = '{32'h3F800000, 32'h40000000,
                            32'h40400000, 32'h40800000};
  logic [31:0] prod [4] = '{32'h40000000, 32'h40800000,
                            32'h40C00000, 32'h41000000};

  logic [31:0] pipe [MUL_LAT];

  fp_mul_arbiter #(
    .DATA_W(DATA_W), .NUM_REQ(NUM_REQ),
    .ID_W(ID_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // normal-only, truncating single-precision multiply
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {a[31] ^ b[31], 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_res = pipe[MUL_LAT-1];

  // scoreboard: pop one expectation per response pulse
  always @(negedge clk) begin : sb
    exp_t e;
    if (rsp_valid != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=%b id=%0d data=%h, required none",
                 rsp_valid, rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_valid !== NUM_REQ'(1 << e.id)) begin
          n_fail++;
          $display("FAIL rsp_valid: got %b, required %b",
                   rsp_valid, NUM_REQ'(1 << e.id));
        end
        n_checks++;
        if (rsp_id !== ID_W'(e.id)) begin
          n_fail++;
          $display("FAIL rsp_id: got %0d, required %0d", rsp_id, e.id);
        end
        n_checks++;
        if (rsp_data !== e.data) begin
          n_fail++;
          $display("FAIL rsp_data: got %h, required %h", rsp_data, e.data);
        end
        n_checks++;
        if (cyc != e.due) begin
          n_fail++;
          $display("FAIL rsp_cycle: got %0d, required %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b0;
    req_valid = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b a=%h b=%h rv=%b d=%h id=%0d busy=%b, required all 0",
               req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single_op();
    int c;
    en = 1'b1;
    set_op(1, 32'h40000000, 32'h40400000);
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    c = cyc;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL t1_grant: got %b, required 0010", req_ready);
    end
    exp_q.push_back('{1, 32'h40C00000, c + LAT});
    @(posedge clk);
    #1 req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin
          n_fail++;
          $display("FAIL t1_issue: got a=%h b=%h, required 40000000 40400000",
                   mul_a, mul_b);
        end
      end
      n_checks++;
      if (busy !== (k <= LAT)) begin
        n_fail++;
        $display("FAIL t1_busy: cycle c+%0d got %b, required %b",
                 k, busy, (k <= LAT));
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t1_drain: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h40000000, opb[i]);
    @(posedge clk);
    #1 req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== NUM_REQ'(1 << (k % 4))) begin
        n_fail++;
        $display("FAIL t2_grant%0d: got %b, required %b",
                 k, req_ready, NUM_REQ'(1 << (k % 4)));
      end
      exp_q.push_back('{k % 4, prod[k % 4], cyc + LAT});
      @(posedge clk);
      #1;
      if (k == 7) req_valid = '0;
    end
    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t2_drain: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    set_op(2, 32'h3FC00000, 32'h40800000);
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL t3_grant0: got %b, required 0100", req_ready);
    end
    exp_q.push_back('{2, 32'h40C00000, cyc + LAT});
    @(posedge clk);
    #1 set_op(2, 32'h3F800000, 32'h3F800000);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL t3_grant1: got %b, required 0100", req_ready);
    end
    exp_q.push_back('{2, 32'h3F800000, cyc + LAT});
    @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t3_drain: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_en_gating();
    int last;
    apply_reset();
    en = 1'b1;
    last = 0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'h40000000, opb[i]);
    @(posedge clk);
    #1 req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== NUM_REQ'(1 << k)) begin
        n_fail++;
        $display("FAIL t4_grant%0d: got %b, required %b",
                 k, req_ready, NUM_REQ'(1 << k));
      end
      exp_q.push_back('{k, prod[k], cyc + LAT});
      last = cyc + LAT;
      @(posedge clk);
      #1;
      if (k == 2) en = 1'b0;
    end
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== '0) begin
        n_fail++;
        $display("FAIL t4_gated: got %b, required 0000", req_ready);
      end
      if (cyc == last) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL t4_busy_last: got %b, required 1", busy);
        end
      end
      if (cyc == last + 1) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL t4_busy_fall: got %b, required 0", busy);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t4_drain: %0d outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL t4_resume: got %b, required 1000", req_ready);
    end
    exp_q.push_back('{3, prod[3], cyc + LAT});
    @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t4_resume_drain: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    en = 1'b1;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL t5_grant: got %b, required 0010", req_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 4'hF;
    #1;
    n_checks++;
    if ({req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL t5_async_clear: rdy=%b a=%h b=%h rv=%b d=%h id=%0d busy=%b, required all 0",
               req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL t5_dropped: rsp_valid=%b busy=%b, required 0000 0",
                 rsp_valid, busy);
      end
    end
    @(posedge clk);
    #1 req_valid = 4'hF;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL t5_first_grant: got %b, required 0001", req_ready);
    end
    exp_q.push_back('{0, prod[0], cyc + LAT});
    @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL t5_drain: %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_idle();
    en = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (mul_a !== '0 || mul_b !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL t6_idle: a=%h b=%h rv=%b busy=%b, required all 0",
                 mul_a, mul_b, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_back_to_back();
    test_en_gating();
    test_reset_midflight();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
